// File: rtl/axi_gain_complex.sv
// axi_gain_complex: complex (I/Q) AXI-Stream gain stage, 3-stage pipeline.
// Each component is multiplied by a signed fixed-point gain (SHIFT fraction
// bits) and arithmetically shifted right by SHIFT, at full precision with no
// saturation. New gains are held pending and take effect at packet boundaries.
// Optional build macro AXI_GAIN_COMPLEX_ROUND_EN: round-half-up instead of
// floor. Latency is the same in both builds.
module axi_gain_complex #(
  parameter int WIDTH_IN   = 16,
  parameter int WIDTH_GAIN = 16,
  parameter int SHIFT      = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [WIDTH_GAIN-1:0]                      gain,
  input  logic                                       gain_stb,
  input  logic [2*WIDTH_IN-1:0]                      i_tdata,
  input  logic                                       i_tlast,
  input  logic                                       i_tvalid,
  output logic                                       i_tready,
  output logic [2*(WIDTH_IN+WIDTH_GAIN-SHIFT)-1:0]   o_tdata,
  output logic                                       o_tlast,
  output logic                                       o_tvalid,
  input  logic                                       o_tready
);

  localparam int WIDTH_OUT = WIDTH_IN + WIDTH_GAIN - SHIFT;
  localparam int PW        = WIDTH_IN + WIDTH_GAIN;
  localparam logic signed [WIDTH_GAIN-1:0] UNITY = WIDTH_GAIN'(1 << SHIFT);
`ifdef AXI_GAIN_COMPLEX_ROUND_EN
  localparam logic signed [PW:0] HALF = (PW+1)'(1) << (SHIFT-1);
`endif

  logic en, accept;

  logic signed [WIDTH_GAIN-1:0] pend_q, pend_d, act_q, act_d;
  logic                         in_pkt_q, in_pkt_d;

  logic                         s1_v_q, s1_last_q;
  logic signed [WIDTH_IN-1:0]   s1_i_q, s1_q_q;
  logic signed [WIDTH_GAIN-1:0] s1_g_q;

  logic                         s2_v_q, s2_last_q;
  logic signed [PW-1:0]         s2_pi_q, s2_pq_q;

  logic                         s3_v_q, s3_last_q;
  logic signed [WIDTH_OUT-1:0]  s3_i_q, s3_q_q, s3_i_d, s3_q_d;

  // Single global enable: the whole pipe advances only when the output slot frees.
  assign en       = !s3_v_q || o_tready;
  assign accept   = i_tvalid && en;
  assign i_tready = en;

  assign o_tdata  = {s3_i_q, s3_q_q};
  assign o_tlast  = s3_last_q;
  assign o_tvalid = s3_v_q;

  // Gain bookkeeping: pending follows the strobe; active is reloaded on the
  // first accepted beat of a packet. Using pend_d lets a strobe coincident with
  // that first beat apply to it; act_d is therefore also the gain for this beat.
  always_comb begin
    pend_d   = gain_stb ? gain : pend_q;
    act_d    = act_q;
    in_pkt_d = in_pkt_q;
    if (accept) begin
      if (!in_pkt_q) act_d = pend_d;
      in_pkt_d = !i_tlast;
    end
  end

  // Final stage: shift the full-precision products down to the output width.
  always_comb begin
`ifdef AXI_GAIN_COMPLEX_ROUND_EN
    logic signed [PW:0] sum_i, sum_q;
    sum_i  = (PW+1)'(s2_pi_q) + HALF;
    sum_q  = (PW+1)'(s2_pq_q) + HALF;
    s3_i_d = WIDTH_OUT'(sum_i >>> SHIFT);
    s3_q_d = WIDTH_OUT'(sum_q >>> SHIFT);
`else
    s3_i_d = WIDTH_OUT'(s2_pi_q >>> SHIFT);
    s3_q_d = WIDTH_OUT'(s2_pq_q >>> SHIFT);
`endif
  end

  // Gain/packet state and the three pipeline stages; stages freeze when en=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= UNITY;
      act_q     <= UNITY;
      in_pkt_q  <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_i_q    <= '0;
      s1_q_q    <= '0;
      s1_g_q    <= UNITY;
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      s2_pi_q   <= '0;
      s2_pq_q   <= '0;
      s3_v_q    <= 1'b0;
      s3_last_q <= 1'b0;
      s3_i_q    <= '0;
      s3_q_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      act_q    <= act_d;
      in_pkt_q <= in_pkt_d;
      if (en) begin
        s1_v_q    <= i_tvalid;
        s1_last_q <= i_tlast;
        s1_i_q    <= i_tdata[2*WIDTH_IN-1:WIDTH_IN];
        s1_q_q    <= i_tdata[WIDTH_IN-1:0];
        s1_g_q    <= act_d;
        s2_v_q    <= s1_v_q;
        s2_last_q <= s1_last_q;
        s2_pi_q   <= PW'(s1_i_q) * PW'(s1_g_q);
        s2_pq_q   <= PW'(s1_q_q) * PW'(s1_g_q);
        s3_v_q    <= s2_v_q;
        s3_last_q <= s2_last_q;
        s3_i_q    <= s3_i_d;
        s3_q_q    <= s3_q_d;
      end
    end
  end

endmodule
